// File: rtl/imem_loader.sv
// Byte-stream program loader: frames UART bytes into 32-bit little-endian words,
// writes them to instruction memory and holds the core until a checksum-valid image lands.
module imem_loader #(
  parameter int          ADDR_W      = 12,
  parameter int          DEPTH_WORDS = 512,
  parameter logic [7:0]  MAGIC       = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [2:0]        o_dbg_state
);

  // Handshake: rx_valid is a one-cycle strobe with no backpressure; every
  // strobe is consumed on the clock edge where it is high, including the
  // cycle in which mem_we is asserted.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [31:0] TMO_LAST = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [7:0]        r_len_lo;
  logic [15:0]       r_len;
  logic [ADDR_W-3:0] r_word_idx;
  logic [1:0]        r_byte_idx;
  logic [31:0]       r_wdata;
  logic [7:0]        r_chk;
  logic              r_mem_we;
  logic [31:0]       r_tmo_cnt;

  logic [15:0]       w_len;
  logic              w_restart;
  logic              w_data_byte;
  logic              w_last_word;
  logic              w_tmo_active;
  logic              w_tmo_hit;

  assign w_len        = {rx_data, r_len_lo};
  assign w_last_word  = (16'(r_word_idx) == (r_len - 16'd1));
  assign w_tmo_active = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                        (r_state == S_DATA)   || (r_state == S_CHK);
  assign w_tmo_hit    = (TIMEOUT_CYC != 0) && w_tmo_active && !rx_valid &&
                        (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_restart    = 1'b0;
    w_data_byte  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid && (rx_data == MAGIC)) begin
          w_next_state = S_LEN_LO;
          w_restart    = 1'b1;
        end
      end
      S_LEN_LO: begin
        if (rx_valid) w_next_state = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          if (w_len > 16'(DEPTH_WORDS)) w_next_state = S_ERR;
          else if (w_len == 16'd0)      w_next_state = S_CHK;
          else                          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        // The final word's write cycle may already carry the checksum byte.
        if (r_mem_we && w_last_word) begin
          if (rx_valid) w_next_state = (rx_data == r_chk) ? S_DONE : S_ERR;
          else          w_next_state = S_CHK;
        end else if (rx_valid) begin
          w_data_byte = 1'b1;
        end
      end
      S_CHK: begin
        if (rx_valid) w_next_state = (rx_data == r_chk) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (rx_valid && (rx_data == MAGIC)) begin
          w_next_state = S_LEN_LO;
          w_restart    = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_tmo_hit) w_next_state = S_ERR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len_lo   <= '0;
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_wdata    <= '0;
      r_chk      <= '0;
      r_mem_we   <= 1'b0;
      r_tmo_cnt  <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_restart) begin
        r_chk      <= '0;
        r_word_idx <= '0;
        r_byte_idx <= '0;
      end
      if ((r_state == S_LEN_LO) && rx_valid) r_len_lo <= rx_data;
      if ((r_state == S_LEN_HI) && rx_valid) r_len    <= w_len;
      if (r_mem_we) r_word_idx <= r_word_idx + 1'b1;
      if (w_data_byte) begin
        r_wdata[{r_byte_idx, 3'b000} +: 8] <= rx_data;
        r_chk      <= r_chk ^ rx_data;
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) r_mem_we <= 1'b1;
      end
      if (rx_valid || !w_tmo_active) r_tmo_cnt <= '0;
      else                           r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end
  end

  assign mem_we      = r_mem_we;
  assign mem_addr    = {r_word_idx, 2'b00};
  assign mem_wdata   = r_wdata;
  assign done        = (r_state == S_DONE);
  assign error       = (r_state == S_ERR);
  assign core_hold   = (r_state != S_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are fed byte by byte, memory writes are
// captured and compared against hand-computed expected writes.
module tb_imem_loader;

  logic        clk;
  logic        reset_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [2:0]  o_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [43:0] exp_q[$];
  logic [43:0] wr_q[$];
  logic [7:0]  tx_q[$];

  imem_loader #(
    .ADDR_W(12), .DEPTH_WORDS(512), .MAGIC(8'hA5), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .error(error), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write capture, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
  end

  // Driver tasks (called at a negedge, return at a negedge)
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic flush_tx(input int gap);
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), gap);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 12'h000) $display("FAIL rst_mem_addr: got %h want 000", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
    n_checks++; if (core_hold !== 1'b1) $display("FAIL rst_core_hold: got %b want 1", core_hold); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL rst_error: got %b want 0", error); else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Two words back to back; checksum 13^6F^F0^DF^FF = AC.
  task automatic test_load_good;
    logic [43:0] e, g;
    wr_q.delete();
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'hF0, 8'hDF, 8'hFF, 8'hAC};
    exp_q = '{{12'h000, 32'h00000013}, {12'h004, 32'hFFDFF06F}};
    flush_tx(0);
    repeat (2) @(negedge clk);
    n_checks++; if (done !== 1'b1) $display("FAIL good_done: got %b want 1", done); else n_pass++;
    n_checks++; if (core_hold !== 1'b0) $display("FAIL good_hold: got %b want 0", core_hold); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL good_error: got %b want 0", error); else n_pass++;
    n_checks++;
    if (wr_q.size() != exp_q.size()) $display("FAIL good_wr_count: got %0d want %0d", wr_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      e = exp_q.pop_front(); g = wr_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL good_wr: got %h want %h", g, e); else n_pass++;
    end
  endtask

  task automatic test_bad_chk;
    logic [43:0] e, g;
    wr_q.delete();
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'hF0, 8'hDF, 8'hFF, 8'h00};
    exp_q = '{{12'h000, 32'h00000013}, {12'h004, 32'hFFDFF06F}};
    flush_tx(1);
    repeat (2) @(negedge clk);
    n_checks++; if (error !== 1'b1) $display("FAIL badchk_error: got %b want 1", error); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL badchk_done: got %b want 0", done); else n_pass++;
    n_checks++; if (core_hold !== 1'b1) $display("FAIL badchk_hold: got %b want 1", core_hold); else n_pass++;
    n_checks++;
    if (wr_q.size() != exp_q.size()) $display("FAIL badchk_wr_count: got %0d want %0d", wr_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      e = exp_q.pop_front(); g = wr_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL badchk_wr: got %h want %h", g, e); else n_pass++;
    end
  endtask

  task automatic test_len_overflow;
    wr_q.delete();
    tx_q = '{8'hA5, 8'h01, 8'h02};
    flush_tx(0);
    n_checks++; if (error !== 1'b1) $display("FAIL ovf_error: got %b want 1", error); else n_pass++;
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    flush_tx(0);
    repeat (3) @(negedge clk);
    n_checks++; if (wr_q.size() != 0) $display("FAIL ovf_no_write: got %0d writes want 0", wr_q.size()); else n_pass++;
    n_checks++; if (core_hold !== 1'b1) $display("FAIL ovf_hold: got %b want 1", core_hold); else n_pass++;
  endtask

  task automatic test_zero_len;
    wr_q.delete();
    tx_q = '{8'h55, 8'h3C};
    flush_tx(0);
    n_checks++; if (error !== 1'b1) $display("FAIL zero_ignored: error got %b want 1", error); else n_pass++;
    send_byte(8'hA5, 0);
    n_checks++; if (error !== 1'b0) $display("FAIL zero_restart: error got %b want 0", error); else n_pass++;
    tx_q = '{8'h00, 8'h00, 8'h00};
    flush_tx(0);
    @(negedge clk);
    n_checks++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else n_pass++;
    n_checks++; if (wr_q.size() != 0) $display("FAIL zero_no_write: got %0d writes want 0", wr_q.size()); else n_pass++;
  endtask

  // Checksum 78^56^34^12 = 08.
  task automatic test_timeout;
    logic [43:0] e, g;
    wr_q.delete();
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h13};
    flush_tx(0);
    repeat (15) @(negedge clk);
    n_checks++; if (error !== 1'b0) $display("FAIL tmo_early: error got %b want 0 at cycle 15", error); else n_pass++;
    @(negedge clk);
    n_checks++; if (error !== 1'b1) $display("FAIL tmo_hit: error got %b want 1 at cycle 16", error); else n_pass++;
    n_checks++; if (wr_q.size() != 0) $display("FAIL tmo_no_write: got %0d writes want 0", wr_q.size()); else n_pass++;
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    exp_q = '{{12'h000, 32'h12345678}};
    flush_tx(2);
    n_checks++; if (done !== 1'b1) $display("FAIL tmo_recover_done: got %b want 1", done); else n_pass++;
    n_checks++;
    if (wr_q.size() != exp_q.size()) $display("FAIL tmo_wr_count: got %0d want %0d", wr_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      e = exp_q.pop_front(); g = wr_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL tmo_wr: got %h want %h", g, e); else n_pass++;
    end
  endtask

  // Full-capacity image: LEN = 512, last write lands at 0x7FC.
  task automatic test_len_limit;
    logic [43:0] e, g;
    logic [31:0] w;
    logic [7:0]  chk;
    int          n_exp;
    wr_q.delete();
    exp_q.delete();
    chk = 8'h00;
    tx_q = '{8'hA5, 8'h00, 8'h02};
    flush_tx(0);
    for (int i = 0; i < 512; i++) begin
      w = {8'hC3, 8'h5A, 8'(i >> 8), 8'(i)};
      exp_q.push_back({12'(i * 4), w});
      for (int k = 0; k < 4; k++) begin
        chk = chk ^ w[8*k +: 8];
        send_byte(w[8*k +: 8], i % 3);
      end
    end
    send_byte(chk, 0);
    @(negedge clk);
    n_checks++; if (done !== 1'b1) $display("FAIL lim_done: got %b want 1", done); else n_pass++;
    n_exp = exp_q.size();
    n_checks++;
    if (wr_q.size() != n_exp) $display("FAIL lim_wr_count: got %0d want %0d", wr_q.size(), n_exp);
    else n_pass++;
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      e = exp_q.pop_front(); g = wr_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL lim_wr: got %h want %h", g, e); else n_pass++;
    end
  endtask

  // Checksum EF^BE^AD^DE = 22.
  task automatic test_reset_mid;
    logic [43:0] e, g;
    wr_q.delete();
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
    flush_tx(0);
    reset_n = 1'b0;
    #1;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL mid_mem_we: got %b want 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 12'h000) $display("FAIL mid_mem_addr: got %h want 000", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 32'h0) $display("FAIL mid_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
    n_checks++; if (core_hold !== 1'b1) $display("FAIL mid_hold: got %b want 1", core_hold); else n_pass++;
    n_checks++; if (done !== 1'b0 || error !== 1'b0) $display("FAIL mid_flags: got done=%b error=%b want 0 0", done, error); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    exp_q = '{{12'h000, 32'hDEADBEEF}};
    flush_tx(0);
    @(negedge clk);
    n_checks++; if (done !== 1'b1) $display("FAIL mid_reload_done: got %b want 1", done); else n_pass++;
    n_checks++;
    if (wr_q.size() != exp_q.size()) $display("FAIL mid_wr_count: got %0d want %0d", wr_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      e = exp_q.pop_front(); g = wr_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL mid_wr: got %h want %h", g, e); else n_pass++;
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_load_good();
    test_bad_chk();
    test_len_overflow();
    test_zero_len();
    test_timeout();
    test_len_limit();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
